// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: walks each instruction through IF/ID/EX/MEM/WB,
// issuing per-phase write strobes and datapath mux selects, and counts retired instructions.
module mc_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic [2:0]       NPCOp,
    output logic [2:0]       WDSel,
    output logic             RFWr,
    output logic [2:0]       WRA3Sel,
    output logic [2:0]       ALUOp,
    output logic             BSel,
    output logic             EXTOp,
    output logic             DMWr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] WLAST = 4'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic pcwr_c, irwr_c, rfwr_c, dmwr_c, illegal_c;
    logic [2:0] npc_c, wdsel_c, wra3_c, alu_c;
    logic bsel_c, ext_c;

    logic is_special, is_add, is_sub, is_sll, is_jr, is_jalr;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
    logic is_jump, is_legal;

    always_comb begin
        is_special = (opcode == 6'b000000);
        is_add     = is_special && (func == 6'b100000);
        is_sub     = is_special && (func == 6'b100010);
        is_sll     = is_special && (func == 6'b000000);
        is_jr      = is_special && (func == 6'b001000);
        is_jalr    = is_special && (func == 6'b001001);
        is_ori     = (opcode == 6'b001101);
        is_lw      = (opcode == 6'b100011);
        is_sw      = (opcode == 6'b101011);
        is_beq     = (opcode == 6'b000100);
        is_lui     = (opcode == 6'b001111);
        is_j       = (opcode == 6'b000010);
        is_jal     = (opcode == 6'b000011);
        is_jump    = is_j | is_jal | is_jr | is_jalr;
        is_legal   = is_jump | is_add | is_sub | is_sll | is_ori | is_lw | is_sw
                   | is_beq | is_lui;
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        retire    = 1'b0;
        pcwr_c    = 1'b0;
        irwr_c    = 1'b0;
        rfwr_c    = 1'b0;
        dmwr_c    = 1'b0;
        illegal_c = 1'b0;
        npc_c     = 3'b000;
        wdsel_c   = 3'b000;
        wra3_c    = 3'b000;
        case (state_q)
            S_IF: begin
                if (wcnt_q == WLAST) begin
                    irwr_c  = 1'b1;
                    pcwr_c  = 1'b1;
                    wcnt_d  = 4'd0;
                    state_d = S_ID;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_ID: begin
                if (is_jump) begin
                    pcwr_c  = 1'b1;
                    npc_c   = (is_j | is_jal) ? 3'b010 : 3'b011;
                    // Link writes PC+4 into $31 (jal) or rd (jalr)
                    if (is_jal | is_jalr) begin
                        rfwr_c  = 1'b1;
                        wdsel_c = 3'b010;
                        wra3_c  = is_jal ? 3'b010 : 3'b001;
                    end
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (!is_legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_beq) begin
                    npc_c   = 3'b001;
                    pcwr_c  = zero;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (is_lw | is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (wcnt_q == WLAST) begin
                    wcnt_d = 4'd0;
                    if (is_sw) begin
                        dmwr_c  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_WB: begin
                rfwr_c  = 1'b1;
                wra3_c  = (is_add | is_sub | is_sll) ? 3'b001 : 3'b000;
                wdsel_c = is_lw ? 3'b001 : 3'b000;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: begin
                wcnt_d  = 4'd0;
                state_d = S_IF;
            end
        endcase
    end

    // ALU operand selects stay valid from EX through WB
    always_comb begin
        alu_c  = 3'b000;
        bsel_c = 1'b0;
        ext_c  = 1'b0;
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            if (is_sub | is_beq) alu_c = 3'b001;
            else if (is_ori)     alu_c = 3'b010;
            else if (is_lui)     alu_c = 3'b011;
            else if (is_sll)     alu_c = 3'b100;
            bsel_c = is_ori | is_lui | is_lw | is_sw;
            ext_c  = is_lw | is_sw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            wcnt_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign PCWr      = pcwr_c & ~reset;
    assign IRWr      = irwr_c & ~reset;
    assign RFWr      = rfwr_c & ~reset;
    assign DMWr      = dmwr_c & ~reset;
    assign illegal   = illegal_c & ~reset;
    assign NPCOp     = npc_c;
    assign WDSel     = wdsel_c;
    assign WRA3Sel   = wra3_c;
    assign ALUOp     = alu_c;
    assign BSel      = bsel_c;
    assign EXTOp     = ext_c;
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: three instances at MEM_LAT 1..3 plus a narrow-counter MEM_LAT=15 instance,
// checked cycle by cycle against a phase-list model of each instruction.
module tb_mc_ctrl;

    typedef enum int {C_ADD, C_SUB, C_SLL, C_JR, C_JALR, C_ORI, C_LW, C_SW,
                      C_BEQ, C_LUI, C_J, C_JAL, C_ILL} cls_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opc = 6'b000010;
    logic [5:0] fnc = 6'b000000;
    logic       zr  = 1'b0;

    logic        pcwr [3];
    logic        irwr [3];
    logic [2:0]  npc  [3];
    logic [2:0]  wdsel[3];
    logic        rfwr [3];
    logic [2:0]  wra3 [3];
    logic [2:0]  alu  [3];
    logic        bsel [3];
    logic        ext  [3];
    logic        dmwr [3];
    logic [2:0]  st   [3];
    logic [31:0] cnt  [3];
    logic        ill  [3];

    logic        w_pcwr, w_irwr, w_rfwr, w_bsel, w_ext, w_dmwr, w_ill;
    logic [2:0]  w_npc, w_wdsel, w_wra3, w_alu, w_st;
    logic [3:0]  w_cnt;

    logic [31:0] exp_cnt[3];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            mc_ctrl #(.MEM_LAT(gi + 1), .CNT_W(32)) u_dut (
                .clk(clk), .reset(rst), .opcode(opc), .func(fnc), .zero(zr),
                .PCWr(pcwr[gi]), .IRWr(irwr[gi]), .NPCOp(npc[gi]), .WDSel(wdsel[gi]),
                .RFWr(rfwr[gi]), .WRA3Sel(wra3[gi]), .ALUOp(alu[gi]), .BSel(bsel[gi]),
                .EXTOp(ext[gi]), .DMWr(dmwr[gi]), .state(st[gi]), .instr_cnt(cnt[gi]),
                .illegal(ill[gi])
            );
        end
    endgenerate

    mc_ctrl #(.MEM_LAT(15), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(rst), .opcode(opc), .func(fnc), .zero(zr),
        .PCWr(w_pcwr), .IRWr(w_irwr), .NPCOp(w_npc), .WDSel(w_wdsel),
        .RFWr(w_rfwr), .WRA3Sel(w_wra3), .ALUOp(w_alu), .BSel(w_bsel),
        .EXTOp(w_ext), .DMWr(w_dmwr), .state(w_st), .instr_cnt(w_cnt),
        .illegal(w_ill)
    );

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        cls_t c;
        c = C_ILL;
        if (o == 6'b000000) begin
            case (f)
                6'b100000: c = C_ADD;
                6'b100010: c = C_SUB;
                6'b000000: c = C_SLL;
                6'b001000: c = C_JR;
                6'b001001: c = C_JALR;
                default:   c = C_ILL;
            endcase
        end else begin
            case (o)
                6'b001101: c = C_ORI;
                6'b100011: c = C_LW;
                6'b101011: c = C_SW;
                6'b000100: c = C_BEQ;
                6'b001111: c = C_LUI;
                6'b000010: c = C_J;
                6'b000011: c = C_JAL;
                default:   c = C_ILL;
            endcase
        end
        return c;
    endfunction

    // Expected outputs for one cycle, given the phase (0..4), whether it is the last
    // cycle of a multi-cycle phase, the instruction class and the zero flag.
    // Layout: illegal,PCWr,IRWr,NPCOp,WDSel,RFWr,WRA3Sel,ALUOp,BSel,EXTOp,DMWr
    function automatic logic [18:0] expect_vec(input int ph, input bit last, input cls_t c,
                                               input logic z);
        logic       e_ill, e_pc, e_ir, e_rf, e_b, e_x, e_dm;
        logic [2:0] e_npc, e_wd, e_wa, e_alu;
        bit         jmp, link, sel;
        jmp   = (c == C_J) || (c == C_JAL) || (c == C_JR) || (c == C_JALR);
        link  = (c == C_JAL) || (c == C_JALR);
        sel   = (ph >= 2) && (ph <= 4);
        e_ill = (ph == 1) && (c == C_ILL);
        e_ir  = (ph == 0) && last;
        e_pc  = e_ir || ((ph == 1) && jmp) || ((ph == 2) && (c == C_BEQ) && z);
        e_npc = 3'd0;
        if (ph == 1 && (c == C_J || c == C_JAL))   e_npc = 3'd2;
        if (ph == 1 && (c == C_JR || c == C_JALR)) e_npc = 3'd3;
        if (ph == 2 && c == C_BEQ)                 e_npc = 3'd1;
        e_wd = 3'd0;
        if (ph == 1 && link)       e_wd = 3'd2;
        if (ph == 4 && c == C_LW)  e_wd = 3'd1;
        e_rf = ((ph == 1) && link) || (ph == 4);
        e_wa = 3'd0;
        if (ph == 1 && c == C_JAL)  e_wa = 3'd2;
        if (ph == 1 && c == C_JALR) e_wa = 3'd1;
        if (ph == 4 && (c == C_ADD || c == C_SUB || c == C_SLL)) e_wa = 3'd1;
        e_alu = 3'd0;
        if (sel) begin
            case (c)
                C_SUB, C_BEQ: e_alu = 3'd1;
                C_ORI:        e_alu = 3'd2;
                C_LUI:        e_alu = 3'd3;
                C_SLL:        e_alu = 3'd4;
                default:      e_alu = 3'd0;
            endcase
        end
        e_b  = sel && (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW);
        e_x  = sel && (c == C_LW || c == C_SW);
        e_dm = (ph == 3) && last && (c == C_SW);
        return {e_ill, e_pc, e_ir, e_npc, e_wd, e_rf, e_wa, e_alu, e_b, e_x, e_dm};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 32'd0;
    endtask

    // Drive one instruction on instance d (starting in IF) and check every cycle.
    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                             input logic z);
        int          lat;
        int          ph[$];
        bit          lastf[$];
        cls_t        c;
        logic [18:0] exp_v, act_v, mask;
        lat = d + 1;
        c   = classify(o, f);
        opc = o; fnc = f; zr = z;
        for (int i = 0; i < lat; i++) begin ph.push_back(0); lastf.push_back(i == lat - 1); end
        ph.push_back(1); lastf.push_back(1'b1);
        if (c inside {C_ADD, C_SUB, C_SLL, C_ORI, C_LUI, C_BEQ, C_LW, C_SW}) begin
            ph.push_back(2); lastf.push_back(1'b1);
        end
        if (c == C_LW || c == C_SW)
            for (int i = 0; i < lat; i++) begin ph.push_back(3); lastf.push_back(i == lat - 1); end
        if (c inside {C_ADD, C_SUB, C_SLL, C_ORI, C_LUI, C_LW}) begin
            ph.push_back(4); lastf.push_back(1'b1);
        end
        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clk);
            exp_v = expect_vec(ph[i], lastf[i], c, z);
            mask  = '1;
            if (ph[i] >= 2 && (c == C_BEQ || c == C_LUI)) mask[1] = 1'b0;
            act_v = {ill[d], pcwr[d], irwr[d], npc[d], wdsel[d], rfwr[d], wra3[d],
                     alu[d], bsel[d], ext[d], dmwr[d]};
            n_checks++;
            if ((act_v & mask) !== (exp_v & mask)) begin
                n_fail++;
                $display("FAIL outputs L=%0d op=%b fn=%b cyc=%0d got=%b want=%b",
                         lat, o, f, i, act_v & mask, exp_v & mask);
            end
            n_checks++;
            if (st[d] !== 3'(ph[i])) begin
                n_fail++;
                $display("FAIL state L=%0d op=%b cyc=%0d got=%0d want=%0d",
                         lat, o, i, st[d], ph[i]);
            end
            @(posedge clk); #1;
        end
        if (c != C_ILL) exp_cnt[d] = exp_cnt[d] + 32'd1;
        n_checks++;
        if (cnt[d] !== exp_cnt[d]) begin
            n_fail++;
            $display("FAIL instr_cnt L=%0d op=%b got=%0d want=%0d", lat, o, cnt[d], exp_cnt[d]);
        end
        n_checks++;
        if (st[d] !== 3'd0) begin
            n_fail++;
            $display("FAIL end_state L=%0d op=%b got=%0d want=0", lat, o, st[d]);
        end
        $display("instr L=%0d op=%b fn=%b zero=%b cycles=%0d cnt=%0d",
                 lat, o, f, z, ph.size(), cnt[d]);
    endtask

    task automatic pick(output logic [5:0] o, output logic [5:0] f);
        int k;
        k = $urandom_range(0, 12);
        o = 6'($urandom);
        f = 6'($urandom);
        case (k)
            0:  begin o = 6'b000000; f = 6'b100000; end
            1:  begin o = 6'b000000; f = 6'b100010; end
            2:  begin o = 6'b000000; f = 6'b000000; end
            3:  begin o = 6'b000000; f = 6'b001000; end
            4:  begin o = 6'b000000; f = 6'b001001; end
            5:  o = 6'b001101;
            6:  o = 6'b100011;
            7:  o = 6'b101011;
            8:  o = 6'b000100;
            9:  o = 6'b001111;
            10: o = 6'b000010;
            11: o = 6'b000011;
            default: begin
                for (int t = 0; t < 100 && classify(o, f) != C_ILL; t++) begin
                    o = 6'($urandom);
                    f = 6'($urandom);
                end
                if (classify(o, f) != C_ILL) o = 6'b010000;
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opc = 6'b000010;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ({pcwr[d], irwr[d], rfwr[d], dmwr[d], ill[d]} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL reset_strobes L=%0d got=%b want=00000", d + 1,
                             {pcwr[d], irwr[d], rfwr[d], dmwr[d], ill[d]});
                end
                n_checks++;
                if (st[d] !== 3'd0 || cnt[d] !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_state L=%0d state=%0d cnt=%0d want 0/0",
                             d + 1, st[d], cnt[d]);
                end
            end
        end
        $display("reset checked");
        do_reset();
    endtask

    task automatic test_add();   do_reset(); run_instr(0, 6'b000000, 6'b100000, 1'b0); endtask
    task automatic test_lw();    do_reset(); run_instr(2, 6'b100011, 6'b010101, 1'b1); endtask
    task automatic test_sw();    do_reset(); run_instr(1, 6'b101011, 6'b000000, 1'b0); endtask

    task automatic test_beq();
        do_reset();
        run_instr(1, 6'b000100, 6'b000000, 1'b0);
        run_instr(1, 6'b000100, 6'b000000, 1'b1);
    endtask

    task automatic test_jumps();
        do_reset();
        run_instr(0, 6'b000011, 6'b000000, 1'b0);
        run_instr(0, 6'b000000, 6'b001000, 1'b0);
        run_instr(0, 6'b000000, 6'b001001, 1'b1);
        run_instr(0, 6'b000010, 6'b111111, 1'b0);
    endtask

    task automatic test_illegal();
        do_reset();
        run_instr(0, 6'b010000, 6'b000000, 1'b0);
        run_instr(0, 6'b000000, 6'b111111, 1'b0);
        run_instr(0, 6'b001101, 6'b000000, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_instr(1, 6'b000000, 6'b100000, 1'b0);
        opc = 6'b101011; fnc = 6'b000000;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dmwr[1] !== 1'b0 || st[1] !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid_mem dmwr=%b state=%0d want 0/3", dmwr[1], st[1]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (st[1] !== 3'd0 || cnt[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_abort state=%0d cnt=%0d want 0/0", st[1], cnt[1]);
        end
        @(negedge clk);
        n_checks++;
        if (dmwr[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_dmwr got=%b want=0", dmwr[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 32'd0;
        $display("reset mid-sw checked");
        run_instr(1, 6'b000000, 6'b100010, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        for (int d = 0; d < 3; d++) begin
            do_reset();
            repeat (25) begin
                pick(o, f);
                run_instr(d, o, f, 1'($urandom));
            end
        end
    endtask

    // j at MEM_LAT=15 takes 16 cycles; 17 of them wrap a 4-bit counter to 1
    task automatic test_wrap();
        int n_ir, first_ir;
        do_reset();
        opc = 6'b000010; fnc = 6'b000000;
        n_ir = 0; first_ir = -1;
        for (int i = 0; i < 17 * 16; i++) begin
            @(negedge clk);
            if (w_irwr === 1'b1) begin
                n_ir++;
                if (first_ir < 0) first_ir = i;
            end
            if (i == 256) begin
                n_checks++;
                if (w_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL wrap_zero got=%0d want=0", w_cnt);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (w_cnt !== 4'd1 || w_st !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_cnt cnt=%0d state=%0d want 1/0", w_cnt, w_st);
        end
        n_checks++;
        if (n_ir != 17 || first_ir != 14) begin
            n_fail++;
            $display("FAIL wrap_irwr count=%0d first=%0d want 17/14", n_ir, first_ir);
        end
        $display("wrap: 17 j at L=15 cnt=%0d irwr=%0d", w_cnt, n_ir);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_beq();
        test_jumps();
        test_illegal();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
mc_ctrl is the multi-cycle successor to the single-cycle control decoder. It sequences each MIPS instruction through the IF/ID/EX/MEM/WB phases, one phase per state. It drives per-phase write strobes plus the same mux selects as the datapath already uses (NPCOp, WDSel, WRA3Sel, ALUOp, BSel, EXTOp). Memory latency is parametrised, and the block keeps a retired-instruction counter and an illegal-instruction flag.

Parameters:
MEM_LAT, 1, cycles per IM fetch and per DM access (legal 1..15)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], from instruction register (stable after IRWr)
func  in  6  IR[5:0]
zero  in  1  ALU equality result, valid in EX
PCWr  out  1  PC write strobe
IRWr  out  1  IR write strobe
NPCOp  out  3  000 PC+4, 001 beq, 010 j/jal, 011 jr/jalr
WDSel  out  3  000 ALU, 001 DM, 010 PC+4
RFWr  out  1  GRF write strobe
WRA3Sel  out  3  000 rt, 001 rd, 010 $31
ALUOp  out  3  000 add, 001 sub, 010 ori, 011 lui, 100 sll
BSel  out  1  1 = immediate operand
EXTOp  out  1  1 = sign-extend
DMWr  out  1  DM write strobe
state  out  3  current state, debug
instr_cnt  out  CNT_W  retired instructions
illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Supported instructions:
  - SPECIAL (opcode 000000) with func add 100000, sub 100010, sll 000000, jr 001000, jalr 001001.
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Every other encoding is illegal.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. The state register and a 4-bit wait counter wcnt are registered; all other outputs are combinational from state, wcnt, opcode, func and zero.
- Reset: state=IF, wcnt=0, instr_cnt=0. While reset is high, PCWr, IRWr, RFWr, DMWr and illegal are forced to 0. Reset mid-instruction abandons the instruction with no further strobes.
- IF:
  - wcnt counts 0..MEM_LAT-1.
  - On the cycle wcnt==MEM_LAT-1: IRWr=1, PCWr=1, NPCOp=000, wcnt clears, next state is ID. Otherwise stay in IF.
- ID (one cycle):
  - j: PCWr=1, NPCOp=010, retire, go to IF.
  - jal: PCWr=1, NPCOp=010, RFWr=1, WRA3Sel=010, WDSel=010, retire, go to IF.
  - jr: PCWr=1, NPCOp=011, retire, go to IF.
  - jalr: as jr, plus RFWr=1, WRA3Sel=001, WDSel=010.
  - Illegal: illegal=1, no other strobe, go to IF, no retire.
  - All other instructions: go to EX.
- EX (one cycle):
  - ALUOp, BSel and EXTOp are per the decode tables; these selects are held valid in EX, MEM and WB.
  - beq: ALUOp=001, NPCOp=001, PCWr=zero, retire, go to IF.
  - lw/sw: BSel=1, EXTOp=1, ALUOp=000, go to MEM.
  - Others: go to WB.
- MEM:
  - wcnt counts 0..MEM_LAT-1.
  - On the last cycle, sw has DMWr=1 (exactly one cycle), retires and goes to IF; lw goes to WB. wcnt clears on exit.
- WB (one cycle):
  - RFWr=1, retire, go to IF.
  - WRA3Sel=001 for add/sub/sll, 000 otherwise.
  - WDSel=001 for lw, 000 otherwise.
- Retire: instr_cnt += 1 at the clock edge ending the retiring cycle. The counter wraps modulo 2^CNT_W.
- Selects outside the states listed above are 000/0.
- A beq not taken is still counted as retired.
- Cycle counts, L=MEM_LAT:
  - j/jal/jr/jalr: L+1
  - beq: L+2
  - R-type/ori/lui: L+3
  - sw: 2L+2
  - lw: 2L+3

Test Plan:
- MEM_LAT=1, reset, then add: state sequence 0,1,2,4. RFWr=1 only in WB with WRA3Sel=001, WDSel=000, ALUOp=000. instr_cnt=1 after 4 cycles.
- MEM_LAT=3, lw: IF held 3 cycles with IRWr only on the 3rd. MEM 3 cycles, DMWr never asserted. WB has WDSel=001, WRA3Sel=000. Total 9 cycles, instr_cnt +1.
- MEM_LAT=2, sw: DMWr high exactly 1 cycle (2nd MEM cycle), BSel=1, EXTOp=1, RFWr never asserted. Total 6 cycles.
- beq with zero=0, then with zero=1: PCWr stays 0 in EX for the first, and is 1 with NPCOp=001 for the second. Both retire, instr_cnt +2.
- jal at MEM_LAT=1: 2 cycles; in ID, PCWr=1, NPCOp=010, RFWr=1, WRA3Sel=010, WDSel=010. Then jr: ID has NPCOp=011, no RFWr.
- Illegal opcode 010000: illegal pulses 1 cycle in ID, back to IF, instr_cnt unchanged. Reset raised in the first MEM cycle of sw at MEM_LAT=2: DMWr never asserted, next state=IF, instr_cnt=0.
